lock_key_scheduler: RTL and testbench
=====================================

Name: lock_key_scheduler

Overview:
- Sequencing controller for a time-varying-key locked FSM.
- Holds NUM_KEYS key slots, loaded over a valid/ready handshake, and presents the correct slot on key_out for each WINDOW-cycle phase.
- Keeps its phase counter aligned with the locked FSM's internal key-window counter; the locked FSM's key inputs are driven directly from key_out.
- Sits between the key-provisioning path and the locked behavioural block.

Parameters:
- KEY_W, 11, width of one key.
- NUM_KEYS, 3, number of key slots / windows per period.
- WINDOW, 6, cycles each key is applied.
- IDX_W, 2, width of slot index (>= clog2(NUM_KEYS)).
- CNT_W, 5, phase counter width (must hold NUM_KEYS*WINDOW-1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- load_valid  in  1  key write request.
- load_ready  out  1  scheduler accepts a key write.
- load_idx  in  IDX_W  target slot.
- load_data  in  KEY_W  key value.
- zeroize  in  1  wipe all slots, return to IDLE.
- enable  in  1  request key streaming.
- sync  in  1  restart phase at 0 (realign with locked FSM reset).
- key_out  out  KEY_W  key currently applied to locked FSM.
- key_idx  out  IDX_W  slot currently on key_out.
- phase_cnt  out  CNT_W  current phase, 0..NUM_KEYS*WINDOW-1.
- window_start  out  1  high when phase_cnt mod WINDOW == 0 in RUN.
- armed  out  1  all slots loaded.
- running  out  1  state == RUN.
- err  out  1  sticky: write to out-of-range index.

Behaviour:
- Reset (rst=1 at rising edge):
  - state=IDLE; all slots=0; loaded mask=0; phase_cnt=0; err=0.
  - Outputs after reset: key_out=0, key_idx=0, window_start=0, armed=0, running=0, load_ready=1.
- States: IDLE (mask incomplete), ARMED (mask all ones, not streaming), RUN.
- load_ready = 1 in IDLE and ARMED, 0 in RUN. Combinational from state only; never depends on load_valid.
- Transfer occurs on a rising edge with load_valid && load_ready:
  - load_idx < NUM_KEYS: slot[load_idx] <= load_data; mask bit set.
  - Rewriting an already-loaded slot overwrites it.
  - load_idx >= NUM_KEYS: write dropped, err <= 1 (cleared only by rst or zeroize).
- armed = &mask (combinational from registered mask).
- Transitions:
  - IDLE -> ARMED on the edge where the last mask bit is set.
  - ARMED -> RUN on an edge with enable=1; phase_cnt <= 0.
  - enable=1 in IDLE is ignored.
  - RUN -> ARMED on an edge with enable=0; phase_cnt <= 0.
  - Any state -> IDLE on zeroize=1: slots, mask, err, phase_cnt cleared.
- Priority at a single edge: rst > zeroize > sync > enable/load.
- RUN counting:
  - phase_cnt increments by 1 each cycle.
  - At NUM_KEYS*WINDOW-1 it wraps to 0 on the next cycle (period 18 cycles by default).
- sync=1 in RUN: phase_cnt <= 0 next edge (overrides increment); state stays RUN. sync outside RUN: no effect.
- key_idx = phase_cnt / WINDOW (combinational from registered phase_cnt).
- key_out = slot[key_idx] in RUN, 0 otherwise; same-cycle, no extra latency.
- Default timing:
  - phase 0..5 -> slot 0.
  - phase 6..11 -> slot 1.
  - phase 12..17 -> slot 2.
- First RUN cycle shows phase_cnt=0 and slot 0.
- window_start = running && (phase_cnt mod WINDOW == 0).
- Alignment contract: the locked FSM must be reset or synced on the same edge as this block's phase restart, so its counter equals phase_cnt every cycle.
- Mid-run loads are impossible (load_ready=0). A load_valid held through RUN completes once the block returns to ARMED.
- All outputs are glitch-free functions of registers; no combinational path from load_valid or enable to outputs.

Test Plan:
- Reset, then load slot0=1886, slot1=178, slot2=635 on consecutive cycles -> armed=1 after the third edge; err=0; key_out=0.
- Armed, enable=1 for 40 cycles -> key_out=1886 for phases 0-5, 178 for 6-11, 635 for 12-17; phase wraps 17->0; window_start high at phases 0, 6, 12.
- In RUN at phase 9, pulse sync -> next cycle phase_cnt=0, key_out=1886; load_valid asserted in RUN -> load_ready=0, slots unchanged.
- Write load_idx=3 with data 5 -> err=1 sticky, no slot change; zeroize -> err=0, armed=0, slots=0, state IDLE; enable then ignored.
- Load only two slots, enable=1 -> running stays 0; load third slot -> ARMED, then RUN on the next edge with enable=1.
- rst asserted mid-RUN at phase 14 together with zeroize and sync -> all outputs at reset values next cycle; load_ready=1.

Source files
------------

// File: rtl/lock_key_scheduler.sv
// Key sequencer for a time-varying-key locked FSM: stores NUM_KEYS keys and
// streams one per WINDOW-cycle phase, kept aligned with the locked FSM counter.
module lock_key_scheduler #(
  parameter int KEY_W    = 11,
  parameter int NUM_KEYS = 3,
  parameter int WINDOW   = 6,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [KEY_W-1:0] load_data,
  input  logic             zeroize,
  input  logic             enable,
  input  logic             sync,
  output logic [KEY_W-1:0] key_out,
  output logic [IDX_W-1:0] key_idx,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             window_start,
  output logic             armed,
  output logic             running,
  output logic             err
);

  localparam int PERIOD = NUM_KEYS * WINDOW;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

  state_t                    state_q, state_d;
  logic [NUM_KEYS-1:0]       mask_q, mask_d;
  logic [CNT_W-1:0]          phase_q, phase_d;
  logic                      err_q, err_d;
  logic                      wr_en;
  logic                      idx_ok;
  logic [NUM_KEYS*KEY_W-1:0] slot_flat;

  // Load datapath: zeroize wipes everything, otherwise accepted writes land
  // in the addressed slot or flag an out-of-range index.
  always_comb begin
    idx_ok = (32'(load_idx) < NUM_KEYS);
    wr_en  = load_valid && load_ready && !zeroize && idx_ok;
    mask_d = mask_q;
    err_d  = err_q;
    if (zeroize) begin
      mask_d = '0;
      err_d  = 1'b0;
    end else if (load_valid && load_ready) begin
      if (!idx_ok) err_d = 1'b1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (wr_en && load_idx == IDX_W'(i)) mask_d[i] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_slot
    logic [KEY_W-1:0] slot_q, slot_d;

    always_comb begin
      slot_d = slot_q;
      if (zeroize) slot_d = '0;
      else if (wr_en && load_idx == IDX_W'(gi)) slot_d = load_data;
    end

    always_ff @(posedge clk) begin
      if (rst) slot_q <= '0;
      else     slot_q <= slot_d;
    end

    assign slot_flat[gi*KEY_W +: KEY_W] = slot_q;
  end

  // Next state and phase; sync outranks enable so a realign never drops RUN.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (zeroize) begin
      state_d = S_IDLE;
      phase_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (&mask_d) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (enable) begin
            state_d = S_RUN;
            phase_d = '0;
          end
        end
        S_RUN: begin
          if (sync) begin
            phase_d = '0;
          end else if (!enable) begin
            state_d = S_ARMED;
            phase_d = '0;
          end else if (phase_q == CNT_W'(PERIOD - 1)) begin
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      phase_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      phase_q <= phase_d;
      err_q   <= err_d;
    end
  end

  // Outputs depend on registered state only; slot select by threshold compare.
  always_comb begin
    load_ready   = (state_q != S_RUN);
    running      = (state_q == S_RUN);
    armed        = &mask_q;
    err          = err_q;
    phase_cnt    = phase_q;
    key_idx      = '0;
    window_start = 1'b0;
    key_out      = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (phase_q >= CNT_W'(i * WINDOW)) key_idx = IDX_W'(i);
      if (phase_q == CNT_W'(i * WINDOW)) window_start = running;
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (running && key_idx == IDX_W'(i)) key_out = slot_flat[i*KEY_W +: KEY_W];
    end
  end

endmodule

// File: tb/tb_lock_key_scheduler.sv
// Directed bench for lock_key_scheduler: loading, streaming, sync, error,
// zeroize and reset-priority scenarios with hand-computed expectations.
module tb_lock_key_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [1:0]  load_idx;
  logic [10:0] load_data;
  logic        zeroize;
  logic        enable;
  logic        sync;
  logic [10:0] key_out;
  logic [1:0]  key_idx;
  logic [4:0]  phase_cnt;
  logic        window_start;
  logic        armed;
  logic        running;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lock_key_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_idx     (load_idx),
    .load_data    (load_data),
    .zeroize      (zeroize),
    .enable       (enable),
    .sync         (sync),
    .key_out      (key_out),
    .key_idx      (key_idx),
    .phase_cnt    (phase_cnt),
    .window_start (window_start),
    .armed        (armed),
    .running      (running),
    .err          (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [1:0] idx, input logic [10:0] data);
    load_valid = 1'b1;
    load_idx   = idx;
    load_data  = data;
    tick();
    load_valid = 1'b0;
    $display("load idx=%0d data=%0d -> armed=%0d err=%0d", idx, data, armed, err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_key_out"},   32'(key_out), 0);
    check_eq({tag, "_key_idx"},   32'(key_idx), 0);
    check_eq({tag, "_phase"},     32'(phase_cnt), 0);
    check_eq({tag, "_wstart"},    32'(window_start), 0);
    check_eq({tag, "_armed"},     32'(armed), 0);
    check_eq({tag, "_running"},   32'(running), 0);
    check_eq({tag, "_ready"},     32'(load_ready), 1);
    check_eq({tag, "_err"},       32'(err), 0);
  endtask

  initial begin
    int exp_phase;
    int exp_key;
    rst = 1'b1; load_valid = 1'b0; load_idx = '0; load_data = '0;
    zeroize = 1'b0; enable = 1'b0; sync = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Load three slots on consecutive cycles
    load_key(2'd0, 11'd1886);
    load_key(2'd1, 11'd178);
    check_eq("armed_after_two", 32'(armed), 0);
    load_key(2'd2, 11'd635);
    check_eq("armed_after_three", 32'(armed), 1);
    check_eq("err_after_load", 32'(err), 0);
    check_eq("key_out_armed", 32'(key_out), 0);
    check_eq("running_armed", 32'(running), 0);

    // Stream 40 cycles
    enable = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      exp_phase = c % 18;
      exp_key   = (exp_phase < 6) ? 1886 : (exp_phase < 12) ? 178 : 635;
      check_eq($sformatf("run_phase_c%0d", c), 32'(phase_cnt), 32'(exp_phase));
      check_eq($sformatf("run_key_c%0d", c), 32'(key_out), 32'(exp_key));
      check_eq($sformatf("run_idx_c%0d", c), 32'(key_idx), 32'(exp_phase / 6));
      check_eq($sformatf("run_ws_c%0d", c), 32'(window_start), (exp_phase % 6 == 0) ? 1 : 0);
      check_eq($sformatf("run_running_c%0d", c), 32'(running), 1);
      check_eq($sformatf("run_ready_c%0d", c), 32'(load_ready), 0);
      tick();
    end
    $display("stream 40 cycles done, phase=%0d", phase_cnt);

    // Now at phase 4; advance to phase 9 then sync with a load attempt
    repeat (5) tick();
    check_eq("phase_before_sync", 32'(phase_cnt), 9);
    sync = 1'b1; load_valid = 1'b1; load_idx = 2'd0; load_data = 11'd7;
    check_eq("ready_in_run", 32'(load_ready), 0);
    tick();
    sync = 1'b0; load_valid = 1'b0;
    $display("sync at phase 9 -> phase=%0d key=%0d", phase_cnt, key_out);
    check_eq("phase_after_sync", 32'(phase_cnt), 0);
    check_eq("key_after_sync", 32'(key_out), 1886);
    check_eq("running_after_sync", 32'(running), 1);
    repeat (6) tick();
    check_eq("slot1_unchanged", 32'(key_out), 178);
    repeat (6) tick();
    check_eq("slot2_unchanged", 32'(key_out), 635);

    // Leave RUN
    enable = 1'b0;
    tick();
    check_eq("stop_running", 32'(running), 0);
    check_eq("stop_key_out", 32'(key_out), 0);
    check_eq("stop_phase", 32'(phase_cnt), 0);
    check_eq("stop_ready", 32'(load_ready), 1);
    check_eq("stop_armed", 32'(armed), 1);

    // Out-of-range write
    load_key(2'd3, 11'd5);
    check_eq("err_set", 32'(err), 1);
    tick();
    check_eq("err_sticky", 32'(err), 1);
    check_eq("armed_after_err", 32'(armed), 1);
    enable = 1'b1;
    tick();
    check_eq("slot0_after_err", 32'(key_out), 1886);
    check_eq("phase_after_err", 32'(phase_cnt), 0);
    enable = 1'b0;
    tick();

    // Zeroize then enable ignored
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    $display("zeroize -> armed=%0d err=%0d running=%0d", armed, err, running);
    check_eq("zero_err", 32'(err), 0);
    check_eq("zero_armed", 32'(armed), 0);
    check_eq("zero_running", 32'(running), 0);
    check_eq("zero_ready", 32'(load_ready), 1);
    enable = 1'b1;
    tick();
    tick();
    check_eq("idle_enable_ignored", 32'(running), 0);
    check_eq("idle_key_out", 32'(key_out), 0);

    // Partial load with enable held, then complete
    load_key(2'd0, 11'd11);
    load_key(2'd1, 11'd22);
    check_eq("partial_running", 32'(running), 0);
    check_eq("partial_armed", 32'(armed), 0);
    load_key(2'd2, 11'd33);
    check_eq("complete_armed", 32'(armed), 1);
    check_eq("complete_not_running", 32'(running), 0);
    tick();
    check_eq("run_after_arm", 32'(running), 1);
    check_eq("run_after_arm_phase", 32'(phase_cnt), 0);
    check_eq("run_after_arm_key", 32'(key_out), 11);
    repeat (14) tick();
    check_eq("phase14", 32'(phase_cnt), 14);
    check_eq("phase14_key", 32'(key_out), 33);

    // rst with zeroize and sync mid-run
    rst = 1'b1; zeroize = 1'b1; sync = 1'b1;
    tick();
    rst = 1'b0; zeroize = 1'b0; sync = 1'b0; enable = 1'b0;
    $display("reset mid-run -> running=%0d ready=%0d", running, load_ready);
    check_reset_outputs("midrun_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
